// File: rtl/bullet_renderer.sv
// bullet_renderer
//
// Purpose:
//   Renders the bullet sprite for the 160x120 VGA adapter. Each drawEn request
//   first erases the previously drawn sprite with BG_COLOUR, then draws the
//   sprite at the new coordinates, emitting one pixel per cycle on the shared
//   vgaX/vgaY/vgaColour/plot interface. busy and done let the top-level arbiter
//   interleave this block with the other renderers.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low reset
//   drawEn     in   render request, only honoured while idle
//   bulletX    in   [7:0] new sprite left x
//   bulletY    in   [6:0] new sprite top y
//   colour     in   [2:0] new sprite colour
//   vgaX       out  [7:0] registered pixel x
//   vgaY       out  [6:0] registered pixel y
//   vgaColour  out  [2:0] registered pixel colour
//   plot       out  registered pixel write strobe
//   busy       out  request in progress (erase, draw and done cycles)
//   done       out  one-cycle completion pulse
//
// Configuration:
//   BULLET_RENDER_CLIP_EN  when defined, pixels with x>=160 or y>=120 still
//                          take their cycle but are not plotted.

module bullet_renderer #(
  parameter int          BULLET_W  = 2,
  parameter int          BULLET_H  = 4,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drawEn,
  input  logic [7:0] bulletX,
  input  logic [6:0] bulletY,
  input  logic [2:0] colour,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] vgaColour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  localparam logic [2:0] COL_LAST = 3'(BULLET_W - 1);
  localparam logic [3:0] ROW_LAST = 4'(BULLET_H - 1);

  state_t     state, nextState;

  logic [7:0] newX, oldX;
  logic [6:0] newY, oldY;
  logic [2:0] newColour;
  logic       oldValid;
  logic [2:0] col;
  logic [3:0] row;
  logic       lastPixel;

  logic [7:0] pixX;
  logic [6:0] pixY;
  logic       onScreen;

  logic [7:0] vgaXNext;
  logic [6:0] vgaYNext;
  logic [2:0] vgaColourNext;
  logic       plotNext, busyNext, doneNext;

  assign lastPixel = (col == COL_LAST) && (row == ROW_LAST);

  // Scan address: erase walks the old sprite, draw walks the new one.
  // Both additions wrap naturally at the port widths.
  assign pixX = ((state == ERASE) ? oldX : newX) + {5'b0, col};
  assign pixY = ((state == ERASE) ? oldY : newY) + {3'b0, row};

`ifdef BULLET_RENDER_CLIP_EN
  assign onScreen = (pixX < 8'd160) && (pixY < 7'd120);
`else
  assign onScreen = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; drawEn only matters in IDLE, so requests during a
  // render are dropped rather than queued.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (drawEn) nextState = oldValid ? ERASE : DRAW;
      ERASE:   if (lastPixel) nextState = DRAW;
      DRAW:    if (lastPixel) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic: computes next values for the registered pixel interface.
  // Coordinates hold whenever no pixel is plotted.
  always_comb begin
    vgaXNext      = vgaX;
    vgaYNext      = vgaY;
    vgaColourNext = vgaColour;
    plotNext      = 1'b0;
    doneNext      = 1'b0;
    busyNext      = (state != IDLE);
    case (state)
      ERASE, DRAW: begin
        if (onScreen) begin
          plotNext      = 1'b1;
          vgaXNext      = pixX;
          vgaYNext      = pixY;
          vgaColourNext = (state == ERASE) ? BG_COLOUR : newColour;
        end
      end
      DONE:    doneNext = 1'b1;
      default: ;
    endcase
  end

  // Output registers: the pixel for a counter value appears one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vgaX      <= 8'd0;
      vgaY      <= 7'd0;
      vgaColour <= 3'd0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      vgaX      <= vgaXNext;
      vgaY      <= vgaYNext;
      vgaColour <= vgaColourNext;
      plot      <= plotNext;
      busy      <= busyNext;
      done      <= doneNext;
    end
  end

  // Datapath: request capture, row-major pixel counters and the record of
  // the last drawn sprite. Reset clears oldValid so an aborted sprite is
  // never erased.
  always_ff @(posedge clk) begin
    if (!reset) begin
      newX      <= 8'd0;
      newY      <= 7'd0;
      newColour <= 3'd0;
      oldX      <= 8'd0;
      oldY      <= 7'd0;
      oldValid  <= 1'b0;
      col       <= 3'd0;
      row       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          col <= 3'd0;
          row <= 4'd0;
          if (drawEn) begin
            newX      <= bulletX;
            newY      <= bulletY;
            newColour <= colour;
          end
        end
        ERASE, DRAW: begin
          if (col == COL_LAST) begin
            col <= 3'd0;
            row <= (row == ROW_LAST) ? 4'd0 : row + 4'd1;
          end else begin
            col <= col + 3'd1;
          end
          if (state == DRAW && lastPixel) begin
            oldX     <= newX;
            oldY     <= newY;
            oldValid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bullet_renderer.md
Name: bullet_renderer

Overview:
- Downstream consumer of the shot controller's bulletX, bulletY, colour and drawEn outputs.
- Each drawEn request erases the previously drawn bullet sprite with the background colour, then draws the sprite at the new coordinates.
- Output is a one-pixel-per-cycle plot stream for the 160x120 VGA adapter, using the shared x/y/colour/plot interface.
- busy and done let the top-level arbiter sequence this block against the alien and rocket renderers.

Parameters:
- BULLET_W, 2: sprite width in pixels (1..4).
- BULLET_H, 4: sprite height in pixels (1..8).
- BG_COLOUR, 3'b000: colour used for erase.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low.
- drawEn  input  1  render request, sampled in IDLE only.
- bulletX  input  8  new sprite left x.
- bulletY  input  7  new sprite top y.
- colour  input  3  new sprite colour.
- vgaX  output  8  pixel x to VGA adapter.
- vgaY  output  7  pixel y to VGA adapter.
- vgaColour  output  3  pixel colour.
- plot  output  1  pixel write strobe.
- busy  output  1  request in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
Reset and clocking:
- Reset is reset, synchronous, active-low; clock is clk.
- In reset: state=IDLE; vgaX=0, vgaY=0, vgaColour=0, plot=0, busy=0, done=0; oldValid=0; old coordinates=0; pixel counters=0.
- Reset mid-operation aborts immediately. plot falls the cycle after reset is sampled, no done pulse is issued, and oldValid is cleared, so the stale sprite is never erased.

FSM states: IDLE, ERASE, DRAW, DONE.
- IDLE: when drawEn=1 at edge k, latch bulletX, bulletY and colour into new*.
  - If oldValid=1, go to ERASE; otherwise go to DRAW.
  - Pixel counters col=0, row=0.
- ERASE: one pixel per cycle at (oldX+col, oldY+row), colour BG_COLOUR, plot=1.
  - Row-major order: col is the inner loop, 0..BULLET_W-1; row is the outer loop, 0..BULLET_H-1.
  - After the last pixel, go to DRAW with counters cleared.
- DRAW: same scan at (newX+col, newY+row) with the latched colour, plot=1.
  - After the last pixel: oldX/oldY <= newX/newY, oldValid <= 1, go to DONE.
- DONE: done=1 for exactly one cycle, plot=0, then go to IDLE.

Outputs and timing:
- vgaX, vgaY, vgaColour and plot are registered. The pixel for a given counter value appears the cycle after that counter value is set.
- With drawEn sampled at edge k:
  - plot is high for cycles k+1..k+N, where N = BULLET_W*BULLET_H when oldValid=0 and 2*BULLET_W*BULLET_H when oldValid=1.
  - done is high at cycle k+N+1.
- busy=1 in ERASE, DRAW and DONE; otherwise 0.
- When plot=0, vgaX, vgaY and vgaColour hold their last values.

Request handling:
- drawEn in any state other than IDLE is ignored. Requests are dropped, not queued.
- drawEn held high re-triggers on the cycle after DONE.
- Inputs are captured only at the IDLE request edge. Changes to them during a render have no effect.

Arithmetic:
- x = oldX/newX + col, truncated to 8 bits (wraps mod 256).
- y = oldY/newY + row, truncated to 7 bits (wraps mod 128).
- No saturation.

Optional Feature:
- Macro: BULLET_RENDER_CLIP_EN.
- Defined: any pixel with x>=160 or y>=120 has plot forced to 0. The pixel still consumes its cycle, so latency is unchanged.
- Undefined: every scanned pixel is plotted, including off-screen addresses.

Test Plan:
- Fresh request after reset: drawEn with X=50, Y=100, colour=111.
  - Required: no erase; 8 plots covering x=50..51, y=100..103, colour 111, first pixel (50,100).
  - Required: done at cycle k+9.
- Follow-up request: drawEn with X=50, Y=95, colour=111.
  - Required: 8 erase plots at (50..51, 100..103), colour 000.
  - Required: then 8 draw plots at (50..51, 95..98), colour 111.
  - Required: done at k+17, busy high k+1..k+17.
- drawEn pulsed at k+3 during a render: ignored. Exactly one done pulse; the plotted coordinates are those latched at k.
- Request X=159, Y=118 after reset:
  - With BULLET_RENDER_CLIP_EN, only (159,118) and (159,119) plot.
  - Without it, all 8 plot, including x=160 and y=120,121.
  - Done timing is identical in both builds.
- Y wrap, X=10, Y=126: scanned y values are 126, 127, 0, 1.
- Reset mid-render: assert reset during ERASE.
  - Required: plot=0 the next cycle, no done pulse.
  - Required: the next request skips erase and finishes after 8 plots plus done.
